// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the serial pattern scan counter.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  localparam int DEF_DATA_W  = 10;
  localparam int DEF_PAT_MAX = 4;
  localparam int DEF_CNT_W   = 4;

  // Lengths above the window depth compare against the full window.
  function automatic int clamp_len(input int pat_len, input int pat_max);
    return (pat_len > pat_max) ? pat_max : pat_len;
  endfunction

endpackage

// File: rtl/pattern_match_window.sv
// Bit history window with valid-bit tracking; flags a match of the low len bits against pat.
module pattern_match_window #(
  parameter int PAT_MAX = 4,
  parameter int LEN_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap_en,
  output logic               match
);

  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] win_next;
  logic [PAT_MAX-1:0] mask;
  logic [LEN_W-1:0]   valid;
  logic [LEN_W-1:0]   valid_next;

  if (PAT_MAX > 1) begin : g_wide
    assign win_next = {window[PAT_MAX-2:0], bit_in};
  end else begin : g_one
    assign win_next = bit_in;
  end

  // The match is judged on the window as it will be after this shift.
  always_comb begin
    valid_next = (valid == LEN_W'(PAT_MAX)) ? valid : valid + 1'b1;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len));
    end
    match = shift_en && (len != '0) && (valid_next >= len) &&
            (((win_next ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
      valid  <= '0;
    end else if (clr) begin
      window <= '0;
      valid  <= '0;
    end else if (shift_en) begin
      window <= win_next;
      // Non-overlapping mode demands a fresh set of bits after each hit.
      valid  <= (match && !overlap_en) ? '0 : valid_next;
    end
  end

endmodule

// File: rtl/pattern_scan_counter.sv
// Captures a word on start, scans it LSB first and reports a saturating pattern count.
module pattern_scan_counter
  import pattern_scan_pkg::*;
#(
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  PAT_MAX = DEF_PAT_MAX,
  parameter int  CNT_W   = DEF_CNT_W,
  localparam int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [PAT_MAX-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic               sat
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t             state;
  logic [DATA_W-1:0]  word;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ov_q;
  logic [IDX_W-1:0]   index;
  logic [CNT_W-1:0]   run_cnt;
  logic               run_sat;
  logic               accept;
  logic               match;

  assign accept = (state == IDLE) && start;

  // Captured scan parameters; only meaningful while a scan is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      word  <= data_in;
      pat_q <= pat;
      len_q <= LEN_W'(clamp_len(int'(pat_len), PAT_MAX));
      ov_q  <= overlap_en;
    end
  end

  pattern_match_window #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .shift_en   (state == SCAN),
    .bit_in     (word[index]),
    .pat        (pat_q),
    .len        (len_q),
    .overlap_en (ov_q),
    .match      (match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      sat     <= 1'b0;
      index   <= '0;
      run_cnt <= '0;
      run_sat <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            busy    <= 1'b1;
            index   <= '0;
            run_cnt <= '0;
            run_sat <= 1'b0;
          end
        end
        SCAN: begin
          if (match) begin
            if (run_cnt == '1) run_sat <= 1'b1;
            else               run_cnt <= run_cnt + 1'b1;
          end
          if (index == IDX_W'(DATA_W - 1)) state <= REPORT;
          else                             index <= index + 1'b1;
        end
        REPORT: begin
          count <= run_cnt;
          sat   <= run_sat;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_counter.sv
// Randomized bench for pattern_scan_counter, two instances (CNT_W=4 and CNT_W=3) sharing stimulus.
module tb_pattern_scan_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       overlap_en = 1'b0;
  logic [9:0] data_in = '0;
  logic [3:0] pat = '0;
  logic [2:0] pat_len = '0;
  logic       busy4, done4, sat4, busy3, done3, sat3;
  logic [3:0] count4;
  logic [2:0] count3;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pattern_scan_counter #(.DATA_W(10), .PAT_MAX(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .pat(pat),
    .pat_len(pat_len), .overlap_en(overlap_en),
    .busy(busy4), .done(done4), .count(count4), .sat(sat4)
  );

  pattern_scan_counter #(.DATA_W(10), .PAT_MAX(4), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .pat(pat),
    .pat_len(pat_len), .overlap_en(overlap_en),
    .busy(busy3), .done(done3), .count(count3), .sat(sat3)
  );

  // Reference: slide over every end position; non-overlap forbids a hit starting inside the previous one.
  function automatic void model(input logic [9:0] d, input logic [3:0] p, input int plen,
                                input bit ov, input int cw, output int cnt, output bit s);
    int l, n, last_end;
    bit hit;
    l = (plen > 4) ? 4 : plen;
    n = 0;
    last_end = -1;
    if (l > 0) begin
      for (int i = l - 1; i < 10; i++) begin
        if (!ov && (i - l + 1) <= last_end) continue;
        hit = 1'b1;
        for (int j = 0; j < l; j++)
          if (d[i - l + 1 + j] != p[l - 1 - j]) hit = 1'b0;
        if (hit) begin
          n++;
          last_end = i;
        end
      end
    end
    s   = (n > (1 << cw) - 1);
    cnt = s ? (1 << cw) - 1 : n;
  endfunction

  // Launches a scan from the current negedge and returns at the negedge where done is seen.
  task automatic run_scan(input logic [9:0] d, input logic [3:0] p, input logic [2:0] len,
                          input bit ov, output int done_m, output bit busy_ok,
                          output logic [3:0] c4, output logic s4,
                          output logic [2:0] c3, output logic s3);
    done_m = -1;
    busy_ok = 1'b1;
    c4 = '0; s4 = 1'b0; c3 = '0; s3 = 1'b0;
    data_in = d; pat = p; pat_len = len; overlap_en = ov; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy4 !== 1'b1 || busy3 !== 1'b1 || done4 !== 1'b0) busy_ok = 1'b0;
    for (int m = 1; m <= 14 && done_m < 0; m++) begin
      data_in = 10'($urandom); pat = 4'($urandom);
      pat_len = 3'($urandom); overlap_en = 1'($urandom);
      @(negedge clk);
      if (done4 === 1'b1) begin
        done_m = m;
        c4 = count4; s4 = sat4; c3 = count3; s3 = sat3;
        if (busy4 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b1) busy_ok = 1'b0;
      end else if (busy4 !== 1'b1 || busy3 !== 1'b1 || done3 !== 1'b0) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy4, done4, count4, sat4} !== 7'd0 || {busy3, done3, count3, sat3} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_values: got dut4=%b dut3=%b want zeros",
               {busy4, done4, count4, sat4}, {busy3, done3, count3, sat3});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [9:0] td [6] = '{10'h36D, 10'h36D, 10'h3FF, 10'h2A5, 10'h00F, 10'h000};
    logic [3:0] tp [6] = '{4'b1011, 4'b1011, 4'b0001, 4'b0101, 4'b1111, 4'b0000};
    logic [2:0] tl [6] = '{3'd4, 3'd4, 3'd1, 3'd0, 3'd7, 3'd1};
    bit         to [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int done_m, e4, e3;
    bit busy_ok, es4, es3;
    logic [3:0] c4;
    logic [2:0] c3;
    logic s4, s3;
    for (int t = 0; t < 6; t++) begin
      model(td[t], tp[t], int'(tl[t]), to[t], 4, e4, es4);
      model(td[t], tp[t], int'(tl[t]), to[t], 3, e3, es3);
      run_scan(td[t], tp[t], tl[t], to[t], done_m, busy_ok, c4, s4, c3, s3);
      n_checks++;
      if (done_m !== 11 || !busy_ok) begin
        n_fail++;
        $display("FAIL directed%0d_timing: done after %0d edges busy_ok=%0b want 11 and 1", t, done_m, busy_ok);
      end
      n_checks++;
      if (c4 !== 4'(e4) || s4 !== es4) begin
        n_fail++;
        $display("FAIL directed%0d_cnt4: got count=%0d sat=%0b want count=%0d sat=%0b", t, c4, s4, e4, es4);
      end
      n_checks++;
      if (c3 !== 3'(e3) || s3 !== es3) begin
        n_fail++;
        $display("FAIL directed%0d_cnt3: got count=%0d sat=%0b want count=%0d sat=%0b", t, c3, s3, e3, es3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [9:0] d;
    logic [3:0] p;
    logic [2:0] l;
    bit ov, busy_ok, es4, es3;
    int done_m, e4, e3;
    logic [3:0] c4;
    logic [2:0] c3;
    logic s4, s3;
    for (int t = 0; t < 40; t++) begin
      d = 10'($urandom); p = 4'($urandom); l = 3'($urandom_range(0, 7)); ov = 1'($urandom);
      if (t % 4 == 0) d = d | 10'($urandom);
      model(d, p, int'(l), ov, 4, e4, es4);
      model(d, p, int'(l), ov, 3, e3, es3);
      run_scan(d, p, l, ov, done_m, busy_ok, c4, s4, c3, s3);
      n_checks++;
      if (done_m !== 11 || !busy_ok || c4 !== 4'(e4) || s4 !== es4 || c3 !== 3'(e3) || s3 !== es3) begin
        n_fail++;
        $display("FAIL random%0d d=%h p=%b l=%0d ov=%0b: got done@%0d busy_ok=%0b c4=%0d s4=%0b c3=%0d s3=%0b want done@11 c4=%0d s4=%0b c3=%0d s3=%0b",
                 t, d, p, l, ov, done_m, busy_ok, c4, s4, c3, s3, e4, es4, e3, es3);
      end
      repeat (t % 3) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int done_m;
    bit busy_ok;
    logic [3:0] c4;
    logic [2:0] c3;
    logic s4, s3;
    run_scan(10'h3FF, 4'b0001, 3'd1, 1'b1, done_m, busy_ok, c4, s4, c3, s3);
    n_checks++;
    if (done_m !== 11 || c4 !== 4'd10 || c3 !== 3'd7 || s3 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got done@%0d c4=%0d c3=%0d s3=%0b want done@11 c4=10 c3=7 s3=1", done_m, c4, c3, s3);
    end
    // Launched in the cycle done is high.
    run_scan(10'h36D, 4'b1011, 3'd4, 1'b0, done_m, busy_ok, c4, s4, c3, s3);
    n_checks++;
    if (done_m !== 11 || !busy_ok || c4 !== 4'd2 || s4 !== 1'b0 || s3 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got done@%0d busy_ok=%0b c4=%0d s4=%0b s3=%0b want done@11 1 2 0 0", done_m, busy_ok, c4, s4, s3);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int ndone, first;
    logic [3:0] c;
    ndone = 0; first = -1; c = '0;
    data_in = 10'h36D; pat = 4'b1011; pat_len = 3'd4; overlap_en = 1'b1; start = 1'b1;
    @(negedge clk);
    for (int m = 1; m <= 30; m++) begin
      if (m == 4) begin
        start = 1'b1;
        data_in = 10'h000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done4 === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = m;
          c = count4;
        end
      end
    end
    n_checks++;
    if (first !== 11 || ndone !== 1 || c !== 4'd3) begin
      n_fail++;
      $display("FAIL start_busy: got first_done@%0d dones=%0d count=%0d want 11 1 3", first, ndone, c);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    int done_m;
    bit busy_ok;
    logic [3:0] c4;
    logic [2:0] c3;
    logic s4, s3;
    seen = 0;
    data_in = 10'h3FF; pat = 4'b0001; pat_len = 3'd1; overlap_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy4 !== 1'b0 || count4 !== 4'd0 || sat4 !== 1'b0 || busy3 !== 1'b0 || count3 !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_scan: got busy=%0b count=%0d sat=%0b count3=%0d want 0 0 0 0", busy4, count4, sat4, count3);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 15; m++) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d cycles with done/busy want 0", seen);
    end
    run_scan(10'h36D, 4'b1011, 3'd4, 1'b1, done_m, busy_ok, c4, s4, c3, s3);
    n_checks++;
    if (done_m !== 11 || !busy_ok || c4 !== 4'd3 || s4 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_recover: got done@%0d busy_ok=%0b count=%0d sat=%0b want 11 1 3 0", done_m, busy_ok, c4, s4);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
